scan_chain_reader: RTL and testbench

SCAN_CHAIN_READER -- requirements
Module: scan_chain_reader

---
 rtl/scan_chain_reader_if.sv | 21 ++
 rtl/scan_chain_reader.sv | 206 ++++++++++++++++++++
 tb/tb_scan_chain_reader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_reader_if.sv
// Word handshake bundle between scan_chain_reader and its consumer.
// The producer holds word_data stable while word_valid is high and word_ready is low.
interface scan_chain_reader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/scan_chain_reader.sv
// Scan-chain load/shift sequencer that packs serial chain data into words.
// Optional SCAN_CHAIN_READER_PARITY_EN appends an XOR word to every readout.
module scan_chain_reader #(
    parameter int SCAN_BITS  = 768,
    parameter int CHAIN_CNT  = 1,
    parameter int WORD_W     = 32,
    parameter int REPEAT_MAX = 4
) (
    input  logic                 fw_pl_clk1,
    input  logic                 fw_rst_n,
    input  logic                 start,
    input  logic [5:0]           cfg_shift_div,
    input  logic [5:0]           cfg_load_delay,
    input  logic [3:0]           cfg_repeat,
    output logic                 scan_load,
    output logic                 scan_clk,
    input  logic [CHAIN_CNT-1:0] scan_out,
    output logic                 busy,
    output logic                 done,
    scan_chain_reader_if.master  word
);
    localparam int SPW = WORD_W / CHAIN_CNT;
    localparam int PW  = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int BW  = $clog2(SCAN_BITS + 1);
    localparam logic [3:0]    REP_CAP  = 4'(REPEAT_MAX);
    localparam logic [PW-1:0] POS_LAST = PW'(SPW - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SCAN_BITS);

    typedef enum logic [2:0] {
        IDLE, LOAD, SHIFT_LO, SHIFT_HI, FLUSH, NEXT, DONE
    } state_t;

    state_t state, nxt;

    logic [5:0]        div_q, load_q, tmr;
    logic [3:0]        rep_q, rd_cnt, rep_eff;
    logic [BW-1:0]     bit_cnt;
    logic [PW-1:0]     pos;
    logic [WORD_W-1:0] acc, acc_nxt, data_q;
    logic              valid_q;
    logic              word_free, tmr_hit, sample, push_tail, word_full;
`ifdef SCAN_CHAIN_READER_PARITY_EN
    logic [WORD_W-1:0] par;
    logic              par_sent, push_par;
`endif

    assign word.word_data  = data_q;
    assign word.word_valid = valid_q;

    assign rep_eff = (cfg_repeat == 4'd0)    ? 4'd1 :
                     (cfg_repeat > REP_CAP)  ? REP_CAP :
                                               cfg_repeat;

    assign word_free = !valid_q || word.word_ready;
    assign tmr_hit   = (tmr == ((state == LOAD) ? load_q : div_q));
    assign word_full = (pos == POS_LAST);
    assign acc_nxt   = acc | (WORD_W'(scan_out) << (int'(pos) * CHAIN_CNT));

    always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt       = state;
        scan_load = 1'b0;
        scan_clk  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        sample    = 1'b0;
        push_tail = 1'b0;
`ifdef SCAN_CHAIN_READER_PARITY_EN
        push_par  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                scan_load = 1'b1;
                busy      = 1'b0;
                if (start) nxt = LOAD;
            end
            LOAD: begin
                scan_load = 1'b1;
                if (tmr_hit) nxt = SHIFT_LO;
            end
            SHIFT_LO: begin
                // a completed word may not overwrite one still pending
                if (tmr_hit && (!word_full || word_free)) begin
                    sample = 1'b1;
                    nxt    = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                scan_clk = 1'b1;
                if (tmr_hit) nxt = (bit_cnt == BIT_LAST) ? FLUSH : SHIFT_LO;
            end
            FLUSH: begin
                if (pos != '0) begin
                    push_tail = word_free;
                end
`ifdef SCAN_CHAIN_READER_PARITY_EN
                else if (!par_sent) begin
                    push_par = word_free;
                end
`endif
                else begin
                    nxt = NEXT;
                end
            end
            NEXT: begin
                if (rd_cnt < rep_q) nxt = LOAD;
                else if (!valid_q) nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            div_q    <= '0;
            load_q   <= '0;
            rep_q    <= '0;
            tmr      <= '0;
            rd_cnt   <= '0;
            bit_cnt  <= '0;
            pos      <= '0;
            acc      <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
`ifdef SCAN_CHAIN_READER_PARITY_EN
            par      <= '0;
            par_sent <= 1'b0;
`endif
        end else begin
            if (nxt != state) begin
                tmr <= '0;
            end else if (state == LOAD || state == SHIFT_HI ||
                         (state == SHIFT_LO && !tmr_hit)) begin
                tmr <= tmr + 6'd1;
            end

            if (state == IDLE && start) begin
                div_q  <= cfg_shift_div;
                load_q <= cfg_load_delay;
                rep_q  <= rep_eff;
                rd_cnt <= '0;
            end
            if (state == FLUSH && nxt == NEXT) rd_cnt <= rd_cnt + 4'd1;

            if (state != LOAD && nxt == LOAD) begin
                bit_cnt  <= '0;
                pos      <= '0;
                acc      <= '0;
`ifdef SCAN_CHAIN_READER_PARITY_EN
                par      <= '0;
                par_sent <= 1'b0;
`endif
            end

            if (sample) begin
                bit_cnt <= bit_cnt + BW'(1);
                if (word_full) begin
                    acc <= '0;
                    pos <= '0;
                end else begin
                    acc <= acc_nxt;
                    pos <= pos + PW'(1);
                end
            end
            if (push_tail) begin
                acc <= '0;
                pos <= '0;
            end

            if (sample && word_full) begin
                data_q  <= acc_nxt;
                valid_q <= 1'b1;
`ifdef SCAN_CHAIN_READER_PARITY_EN
                par     <= par ^ acc_nxt;
`endif
            end else if (push_tail) begin
                data_q  <= acc;
                valid_q <= 1'b1;
`ifdef SCAN_CHAIN_READER_PARITY_EN
                par     <= par ^ acc;
`endif
            end
`ifdef SCAN_CHAIN_READER_PARITY_EN
            else if (push_par) begin
                data_q   <= par;
                valid_q  <= 1'b1;
                par_sent <= 1'b1;
            end
`endif
            else if (word.word_ready) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_scan_chain_reader.sv
// Self-checking bench for scan_chain_reader: default instance plus a
// 4-chain, 10-bit instance, checked against a readout model.
module tb_scan_chain_reader;
`ifdef SCAN_CHAIN_READER_PARITY_EN
    localparam int WPR0 = 25;
    localparam int WPR1 = 3;
`else
    localparam int WPR0 = 24;
    localparam int WPR1 = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start0, start1;
    logic [5:0] div0, ld0, div1, ld1;
    logic [3:0] rep0, rep1;
    logic       sload0, sclk0, busy0, done0;
    logic       sload1, sclk1, busy1, done1;
    logic [0:0] sout0;
    logic [3:0] sout1;

    scan_chain_reader_if #(.WORD_W(32)) bus0 ();
    scan_chain_reader_if #(.WORD_W(32)) bus1 ();

    scan_chain_reader dut0 (
        .fw_pl_clk1     (clk),
        .fw_rst_n       (rst_n),
        .start          (start0),
        .cfg_shift_div  (div0),
        .cfg_load_delay (ld0),
        .cfg_repeat     (rep0),
        .scan_load      (sload0),
        .scan_clk       (sclk0),
        .scan_out       (sout0),
        .busy           (busy0),
        .done           (done0),
        .word           (bus0)
    );

    scan_chain_reader #(
        .SCAN_BITS (10),
        .CHAIN_CNT (4),
        .WORD_W    (32),
        .REPEAT_MAX(4)
    ) dut1 (
        .fw_pl_clk1     (clk),
        .fw_rst_n       (rst_n),
        .start          (start1),
        .cfg_shift_div  (div1),
        .cfg_load_delay (ld1),
        .cfg_repeat     (rep1),
        .scan_load      (sload1),
        .scan_clk       (sclk1),
        .scan_out       (sout1),
        .busy           (busy1),
        .done           (done1),
        .word           (bus1)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // chain contents: mode 0 alternating 1,0; mode 1 irregular; mode 2 c[0]
    function automatic logic pat(input int mode, input int c, input int k);
        if (mode == 0) return logic'(k % 2 == 0);
        if (mode == 1) return logic'((k % 3 == 0) != (k % 7 == 2));
        return logic'(c % 2);
    endfunction

    int mode0 = 0;
    int idx0 = 0;
    int idx1 = 0;
    always @(posedge sclk0 or posedge sload0)
        if (sload0) idx0 <= 0;
        else idx0 <= idx0 + 1;
    always @(posedge sclk1 or posedge sload1)
        if (sload1) idx1 <= 0;
        else idx1 <= idx1 + 1;
    always_comb sout0[0] = pat(mode0, 0, idx0);
    always_comb begin
        sout1 = '0;
        for (int c = 0; c < 4; c++) sout1[c] = pat(2, c, idx1);
    end

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    // expected words of one readout: chain c, sample k -> stream bit k*nc+c
    task automatic model(input int which, input int mode);
        int nc, sb, nw;
        logic [31:0] ws[32];
        logic [31:0] px;
        nc = (which != 0) ? 4 : 1;
        sb = (which != 0) ? 10 : 768;
        nw = (sb * nc + 31) / 32;
        for (int i = 0; i < 32; i++) ws[i] = '0;
        for (int k = 0; k < sb; k++) begin
            for (int c = 0; c < nc; c++) begin
                int b;
                b = k * nc + c;
                ws[b / 32][b % 32] = pat(mode, c, k);
            end
        end
        px = '0;
        for (int w = 0; w < nw; w++) begin
            px = px ^ ws[w];
            if (which != 0) q1.push_back(ws[w]);
            else q0.push_back(ws[w]);
        end
`ifdef SCAN_CHAIN_READER_PARITY_EN
        if (which != 0) q1.push_back(px);
        else q0.push_back(px);
`endif
    endtask

    int rmode = 0;
    int cyc = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rmode == 0) bus0.word_ready = 1'b1;
        else if (rmode == 1) bus0.word_ready = (cyc % 3 != 0);
        else bus0.word_ready = 1'b0;
    end

    int cur_div = 0;
    int cur_ld = 0;
    int hi_run = 0;
    int ld_run = 0;
    int rises = 0;
    int loads = 0;
    int dones0 = 0;
    int dones1 = 0;
    int acc0 = 0;
    int acc1 = 0;
    logic pv0 = 0;
    logic pr0 = 0;
    logic [31:0] pd0 = '0;
    logic psclk = 0;
    logic pdone0 = 0;
    logic pdone1 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv0 = 0;
            psclk = 0;
            hi_run = 0;
            ld_run = 0;
            pdone0 = 0;
            pdone1 = 0;
        end else begin
            if (pv0 && !pr0) begin
                check("hold_valid0", 32'(bus0.word_valid), 32'd1);
                check("hold_data0", bus0.word_data, pd0);
            end
            if (bus0.word_valid && bus0.word_ready) begin
                check("word_avail0", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) check("word0", bus0.word_data, q0.pop_front());
                acc0++;
            end
            pv0 = bus0.word_valid;
            pr0 = bus0.word_ready;
            pd0 = bus0.word_data;

            if (sclk0) begin
                if (!psclk) rises++;
                hi_run++;
            end else if (psclk) begin
                check("hi_len", 32'(hi_run), 32'(cur_div + 1));
                hi_run = 0;
            end
            psclk = sclk0;

            if (sload0 && busy0) begin
                ld_run++;
            end else if (ld_run > 0) begin
                check("load_len", 32'(ld_run), 32'(cur_ld + 1));
                loads++;
                ld_run = 0;
            end

            if (done0) begin
                dones0++;
                check("done0_words_left", 32'(q0.size()), 32'd0);
                check("done0_width", 32'(pdone0), 32'd0);
            end
            pdone0 = done0;

            if (bus1.word_valid && bus1.word_ready) begin
                check("word_avail1", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) check("word1", bus1.word_data, q1.pop_front());
                acc1++;
            end
            if (done1) begin
                dones1++;
                check("done1_width", 32'(pdone1), 32'd0);
            end
            pdone1 = done1;
        end
    end

    task automatic check_idle(input string t);
        check({t, "_load0"}, 32'(sload0), 32'd1);
        check({t, "_sclk0"}, 32'(sclk0), 32'd0);
        check({t, "_data0"}, bus0.word_data, 32'd0);
        check({t, "_valid0"}, 32'(bus0.word_valid), 32'd0);
        check({t, "_busy0"}, 32'(busy0), 32'd0);
        check({t, "_done0"}, 32'(done0), 32'd0);
        check({t, "_valid1"}, 32'(bus1.word_valid), 32'd0);
        check({t, "_busy1"}, 32'(busy1), 32'd0);
    endtask

    task automatic start_run(input int div, input int ld, input int rep);
        rises = 0;
        loads = 0;
        dones0 = 0;
        acc0 = 0;
        cur_div = div;
        cur_ld = ld;
        @(posedge clk);
        #1;
        div0 = 6'(div);
        ld0 = 6'(ld);
        rep0 = 4'(rep);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        div0 = 6'd9;
        ld0 = 6'd7;
        rep0 = 4'd2;
    endtask

    task automatic wait_done0(output bit ok);
        ok = 0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            start0 = (i == 200);
            if (done0) begin
                ok = 1;
                break;
            end
        end
        start0 = 1'b0;
    endtask

    task automatic finish_checks(input int reps, input bit ok);
        check("done_seen", 32'(ok), 32'd1);
        @(negedge clk);
        check("rises", 32'(rises), 32'(768 * reps));
        check("loads", 32'(loads), 32'(reps));
        check("done_pulses", 32'(dones0), 32'd1);
        check("words", 32'(acc0), 32'(WPR0 * reps));
        check("queue_empty", 32'(q0.size()), 32'd0);
        check("idle_busy", 32'(busy0), 32'd0);
    endtask

    task automatic run0(input int div, input int ld, input int rep,
                        input int mode, input int rm, input int reps);
        bit ok;
        mode0 = mode;
        rmode = rm;
        for (int r = 0; r < reps; r++) model(0, mode);
        start_run(div, ld, rep);
        wait_done0(ok);
        finish_checks(reps, ok);
    endtask

    initial begin
        bit ok;
        int r80, a;
        logic [31:0] d0;
        start0 = 0;
        start1 = 0;
        div0 = 0;
        ld0 = 0;
        rep0 = 1;
        div1 = 6'd1;
        ld1 = 6'd2;
        rep1 = 4'd1;
        bus1.word_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("rst");
        @(negedge clk);
        #2 rst_n = 1'b1;

        model(0, 0);
        check("pin_alt_w0", q0[0], 32'h55555555);
        check("pin_alt_w23", q0[23], 32'h55555555);
`ifdef SCAN_CHAIN_READER_PARITY_EN
        check("pin_alt_par", q0[24], 32'h00000000);
`endif
        q0.delete();
        model(0, 1);
        check("pin_irr_w0", q0[0], 32'h09A5904D);
        q0.delete();

        run0(0, 3, 1, 0, 0, 1);

        mode0 = 0;
        rmode = 2;
        model(0, 0);
        start_run(0, 3, 1);
        ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (bus0.word_valid) ok = 1;
        end
        check("stall_first_valid", 32'(ok), 32'd1);
        d0 = bus0.word_data;
        r80 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 80) r80 = rises;
        end
        check("stall_sclk", 32'(sclk0), 32'd0);
        check("stall_frozen", 32'(rises), 32'(r80));
        check("stall_data", bus0.word_data, d0);
        check("stall_valid", 32'(bus0.word_valid), 32'd1);
        rmode = 0;
        wait_done0(ok);
        finish_checks(1, ok);

        run0(0, 3, 9, 1, 1, 4);
        run0(2, 0, 0, 1, 0, 1);

        mode0 = 0;
        rmode = 0;
        model(0, 0);
        start_run(0, 3, 1);
        ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (acc0 >= 10) ok = 1;
        end
        check("abort_reach", 32'(ok), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("abort");
        q0.delete();
        a = acc0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("abort_no_done", 32'(dones0), 32'd0);
        check("abort_no_words", 32'(acc0), 32'(a));
        check("abort_idle", 32'(busy0), 32'd0);
        run0(1, 5, 2, 0, 0, 2);

        model(1, 2);
        check("pin_c4_w0", q1[0], 32'hAAAAAAAA);
        check("pin_c4_w1", q1[1], 32'h000000AA);
        acc1 = 0;
        dones1 = 0;
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (done1) ok = 1;
        end
        check("c4_done_seen", 32'(ok), 32'd1);
        @(negedge clk);
        check("c4_words", 32'(acc1), 32'(WPR1));
        check("c4_queue_empty", 32'(q1.size()), 32'd0);
        check("c4_done_pulses", 32'(dones1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
